line_buffer_multi: RTL and testbench

- Parametrised multi-channel line buffer that delivers a vertical column of BUF_DEPTH pixels (current line plus the previous BUF_DEPTH-1 lines at the same column) for every accepted input pixel.
- Sits between the video input/colour-conversion stage and the KxK window/filter stages. It is the next generation of the single-channel line buffer.
- Adds channel packing, write addressing gated by data-valid, frame start handling, top-border fill modes and overflow detection.

---
 rtl/line_buffer_multi.sv | 232 +++++++++++++++++++++++
 tb/tb_line_buffer_multi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_multi.sv
// -----------------------------------------------------------------------------
// line_buffer_multi
//
// Multi-channel line buffer. For every accepted input pixel it delivers, one
// cycle later, a vertical column of BUF_DEPTH pixels: the current pixel on
// tap 0 and the pixels at the same column of the previous BUF_DEPTH-1 lines
// on taps 1..BUF_DEPTH-1. Lines not yet received in the current frame are
// filled with zero (BORDER_MODE 0) or with the oldest valid line
// (BORDER_MODE 1).
//
// The BUF_DEPTH-1 line stores are used as a ring: line n of the frame is
// written into store (n mod (BUF_DEPTH-1)). Every accepted pixel reads all
// stores at its column. The store being overwritten still returns its old
// contents (line n-(BUF_DEPTH-1)) because reads happen before writes at the
// same address. Tap k is then the store that was written k lines ago.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   data_i         input pixel, CHANNELS x COLORDEPTH, channel 0 in the LSBs
//   dv_i           input pixel valid
//   line_end       last cycle of a line
//   frame_start    first cycle of a frame
//   dv_o           output taps valid (one cycle after each accepted pixel)
//   buff_o         BUF_DEPTH taps, tap k in bits [(k+1)*W-1 : k*W], tap 0 = current line
//   lines_valid_o  bit k set when tap k holds a real line of this frame
//   overflow_o     sticky flag: a line exceeded MAX_WIDTH pixels
// -----------------------------------------------------------------------------
module line_buffer_multi #(
  parameter int COLORDEPTH  = 8,
  parameter int CHANNELS    = 3,
  parameter int MAX_WIDTH   = 2048,
  parameter int BUF_DEPTH   = 3,
  parameter int BORDER_MODE = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [CHANNELS*COLORDEPTH-1:0]           data_i,
  input  logic                                     dv_i,
  input  logic                                     line_end,
  input  logic                                     frame_start,
  output logic                                     dv_o,
  output logic [BUF_DEPTH*CHANNELS*COLORDEPTH-1:0] buff_o,
  output logic [BUF_DEPTH-1:0]                     lines_valid_o,
  output logic                                     overflow_o
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int W     = CHANNELS * COLORDEPTH;
  localparam int NST   = BUF_DEPTH - 1;                          // number of line stores
  localparam int AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1; // memory address width
  localparam int COL_W = $clog2(MAX_WIDTH + 1);                  // col must be able to hold MAX_WIDTH
  localparam int LC_W  = $clog2(BUF_DEPTH);
  localparam int SEL_W = (NST > 1) ? $clog2(NST) : 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH);
  localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(BUF_DEPTH - 1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NST - 1);

  // Store holding the line written k lines before the one in store 'sel'.
  function automatic logic [SEL_W-1:0] store_of(input logic [SEL_W-1:0] sel, input int k);
    int v;
    v = int'(sel) + NST - k;
    if (v >= NST) v = v - NST;
    return SEL_W'(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Input-side state
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] r_col;       // next column to be written in the current line
  logic [LC_W-1:0]  r_line_cnt;  // lines completed in this frame, saturating
  logic [SEL_W-1:0] r_wr_sel;    // store receiving the current line
  logic             r_overflow;

  // frame_start restarts the frame in the same cycle, so the pixel that comes
  // with it already sees column 0 / line 0 / store 0.
  logic [COL_W-1:0]     w_col_eff;
  logic [LC_W-1:0]      w_lc_eff;
  logic [SEL_W-1:0]     w_sel_eff;
  logic [AW-1:0]        w_addr;
  logic                 w_accept;
  logic                 w_drop;
  logic [BUF_DEPTH-1:0] w_lv_now;

  logic [COL_W-1:0] w_col_nxt;
  logic [LC_W-1:0]  w_lc_nxt;
  logic [SEL_W-1:0] w_sel_nxt;

  assign w_col_eff = frame_start ? '0 : r_col;
  assign w_lc_eff  = frame_start ? '0 : r_line_cnt;
  assign w_sel_eff = frame_start ? '0 : r_wr_sel;
  assign w_accept  = dv_i && (w_col_eff < COL_MAX);
  assign w_drop    = dv_i && !w_accept;
  assign w_addr    = w_col_eff[AW-1:0];

  // NOTE: every variable written in an always_comb gets a default value at the
  // top of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_lv_now = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      w_lv_now[k] = (k <= int'(w_lc_eff));
    end
  end

  always_comb begin
    w_col_nxt = r_col;
    if (line_end) begin
      w_col_nxt = '0;
    end else if (frame_start) begin
      w_col_nxt = w_accept ? COL_W'(1) : '0;
    end else if (w_accept) begin
      // col stops at MAX_WIDTH because no pixel is accepted there.
      w_col_nxt = r_col + COL_W'(1);
    end
  end

  always_comb begin
    w_lc_nxt  = r_line_cnt;
    w_sel_nxt = r_wr_sel;
    if (frame_start) begin
      // frame_start wins over a coincident line_end.
      w_lc_nxt  = '0;
      w_sel_nxt = '0;
    end else if (line_end) begin
      if (r_line_cnt != LC_MAX) w_lc_nxt = r_line_cnt + LC_W'(1);
      w_sel_nxt = (r_wr_sel == SEL_MAX) ? '0 : r_wr_sel + SEL_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col      <= '0;
      r_line_cnt <= '0;
      r_wr_sel   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_col      <= w_col_nxt;
      r_line_cnt <= w_lc_nxt;
      r_wr_sel   <= w_sel_nxt;
      if (frame_start) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line stores: synchronous read, read-before-write
  // ---------------------------------------------------------------------------
  logic [W-1:0] r_mem [NST][MAX_WIDTH];
  logic [W-1:0] r_rd  [NST];

  // NOTE: the memories and their read registers have no reset so they map onto
  // block RAM; their contents are only shown once lines_valid_o marks them real.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < NST; j++) begin
        r_rd[j] <= r_mem[j][w_addr];
      end
      r_mem[w_sel_eff][w_addr] <= data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers, updated together with the memory read
  // ---------------------------------------------------------------------------
  logic                 r_dv;
  logic [W-1:0]         r_tap0;
  logic [LC_W-1:0]      r_lc_q;
  logic [SEL_W-1:0]     r_sel_q;
  logic [BUF_DEPTH-1:0] r_lv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dv    <= 1'b0;
      r_tap0  <= '0;
      r_lc_q  <= '0;
      r_sel_q <= '0;
      r_lv    <= '0;
    end else begin
      r_dv <= w_accept;
      if (w_accept) begin
        r_tap0  <= data_i;
        r_lc_q  <= w_lc_eff;
        r_sel_q <= w_sel_eff;
        r_lv    <= w_lv_now;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tap assembly and border fill. Everything feeding this mux only changes on
  // an accepted pixel, so buff_o holds while dv_o is low. Right after reset
  // r_lv is zero and r_tap0 is zero, so undefined memory never reaches buff_o.
  // ---------------------------------------------------------------------------
  logic [W-1:0] w_raw [BUF_DEPTH];

  always_comb begin
    for (int k = 0; k < BUF_DEPTH; k++) begin
      w_raw[k] = '0;
    end
    w_raw[0] = r_tap0;
    for (int k = 1; k < BUF_DEPTH; k++) begin
      w_raw[k] = r_rd[store_of(r_sel_q, k)];
    end
  end

  always_comb begin
    buff_o = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (r_lv[k]) begin
        buff_o[k*W +: W] = w_raw[k];
      end else if (BORDER_MODE == 1) begin
        // Replicate the oldest line that exists in this frame.
        buff_o[k*W +: W] = w_raw[r_lc_q];
      end else begin
        buff_o[k*W +: W] = '0;
      end
    end
  end

  assign dv_o          = r_dv;
  assign lines_valid_o = r_lv;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_line_buffer_multi.sv
// -----------------------------------------------------------------------------
// Testbench for line_buffer_multi. Two instances share the stimulus: one with
// zero border fill, one with replicate border fill (MAX_WIDTH=8, BUF_DEPTH=3).
// A behavioural model keeps every line of the frame by absolute line number
// and pushes the expected taps into a queue for each accepted pixel; the queue
// is popped whenever the DUT raises dv_o.
// -----------------------------------------------------------------------------
module tb_line_buffer_multi;

  localparam int CD = 8;
  localparam int CH = 3;
  localparam int MW = 8;
  localparam int BD = 3;
  localparam int W  = CD * CH;
  localparam int BW = BD * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_i;
  logic          dv_i;
  logic          line_end;
  logic          frame_start;

  logic          dv0, dv1;
  logic [BW-1:0] buff0, buff1;
  logic [BD-1:0] lv0, lv1;
  logic          ovf0, ovf1;

  always #5 clk = ~clk;

  line_buffer_multi #(
    .COLORDEPTH(CD), .CHANNELS(CH), .MAX_WIDTH(MW), .BUF_DEPTH(BD), .BORDER_MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .data_i(data_i), .dv_i(dv_i), .line_end(line_end),
    .frame_start(frame_start), .dv_o(dv0), .buff_o(buff0), .lines_valid_o(lv0),
    .overflow_o(ovf0)
  );

  line_buffer_multi #(
    .COLORDEPTH(CD), .CHANNELS(CH), .MAX_WIDTH(MW), .BUF_DEPTH(BD), .BORDER_MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .data_i(data_i), .dv_i(dv_i), .line_end(line_end),
    .frame_start(frame_start), .dv_o(dv1), .buff_o(buff1), .lines_valid_o(lv1),
    .overflow_o(ovf1)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [BW-1:0] pk(input logic [W-1:0] t2, input logic [W-1:0] t1,
                                       input logic [W-1:0] t0);
    return {t2, t1, t0};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [BW-1:0] b0;
    logic [BW-1:0] b1;
    logic [BD-1:0] lv;
  } exp_t;

  exp_t          sb[$];
  int            m_col, m_lc, m_n;
  logic          m_ovf;
  logic [W-1:0]  fr [64][MW];
  logic [BW-1:0] last0, last1;
  logic [BD-1:0] last_lv;

  task automatic model_reset();
    m_col = 0; m_lc = 0; m_n = 0; m_ovf = 1'b0;
    sb.delete();
    last0 = '0; last1 = '0; last_lv = '0;
  endtask

  // One clock cycle of stimulus, model update and output comparison.
  task automatic step(input logic dv, input logic le, input logic fs, input logic [W-1:0] d);
    exp_t         e;
    int           ce, lce, ne;
    logic         acc;
    logic [W-1:0] t0 [BD];
    logic [W-1:0] t1 [BD];
    @(negedge clk);
    dv_i = dv; line_end = le; frame_start = fs; data_i = d;
    ce  = fs ? 0 : m_col;
    lce = fs ? 0 : m_lc;
    ne  = fs ? 0 : m_n;
    acc = dv && (ce < MW);
    if (acc) begin
      for (int k = 0; k < BD; k++) begin
        if (k == 0)        t0[k] = d;
        else if (k <= lce) t0[k] = fr[(ne - k) & 63][ce];
        else               t0[k] = '0;
      end
      for (int k = 0; k < BD; k++) t1[k] = (k <= lce) ? t0[k] : t0[lce];
      e.b0 = {t0[2], t0[1], t0[0]};
      e.b1 = {t1[2], t1[1], t1[0]};
      for (int k = 0; k < BD; k++) e.lv[k] = (k <= lce);
      fr[ne & 63][ce] = d;
      sb.push_back(e);
    end
    if (le)       m_col = 0;
    else if (fs)  m_col = acc ? 1 : 0;
    else if (acc) m_col = m_col + 1;
    if (fs)                      m_ovf = 1'b0;
    else if (dv && ce == MW)     m_ovf = 1'b1;
    if (fs) begin
      m_lc = 0; m_n = 0;
    end else if (le) begin
      if (m_lc < BD - 1) m_lc = m_lc + 1;
      m_n = m_n + 1;
    end
    @(posedge clk);
    #1;
    check("dv_o", BW'(dv0), BW'(acc));
    check("dv_o mode1", BW'(dv1), BW'(acc));
    check("overflow_o", BW'(ovf0), BW'(m_ovf));
    if (dv0) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard: dv_o high with no expected pixel (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        last0 = e.b0; last1 = e.b1; last_lv = e.lv;
      end
    end
    check("buff_o", buff0, last0);
    check("buff_o mode1", buff1, last1);
    check("lines_valid_o", BW'(lv0), BW'(last_lv));
  endtask

  // ---------------------------------------------------------------------------
  // Hand-computed vector table: short 2-pixel lines, border fill, saturation
  // of line_cnt, and frame_start + line_end + dv_i in one cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          dv;
    logic          le;
    logic          fs;
    logic [W-1:0]  d;
    logic          e_dv;
    logic [BD-1:0] e_lv;
    logic [BW-1:0] e_b0;
    logic [BW-1:0] e_b1;
  } vec_t;

  localparam logic [W-1:0] Z = '0;

  initial begin
    vec_t         tbl [12];
    logic [W-1:0] px;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 24'h11, 1'b1, 3'b001, pk(Z, Z, 24'h11),         pk(24'h11, 24'h11, 24'h11)};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 24'h12, 1'b1, 3'b001, pk(Z, Z, 24'h12),         pk(24'h12, 24'h12, 24'h12)};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 24'h21, 1'b1, 3'b011, pk(Z, 24'h11, 24'h21),    pk(24'h11, 24'h11, 24'h21)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 24'h99, 1'b0, 3'b011, pk(Z, 24'h11, 24'h21),    pk(24'h11, 24'h11, 24'h21)};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 24'h22, 1'b1, 3'b011, pk(Z, 24'h12, 24'h22),    pk(24'h12, 24'h12, 24'h22)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h31, 1'b1, 3'b111, pk(24'h11, 24'h21, 24'h31), pk(24'h11, 24'h21, 24'h31)};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 24'h32, 1'b1, 3'b111, pk(24'h12, 24'h22, 24'h32), pk(24'h12, 24'h22, 24'h32)};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 24'h41, 1'b1, 3'b111, pk(24'h21, 24'h31, 24'h41), pk(24'h21, 24'h31, 24'h41)};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 24'h51, 1'b1, 3'b001, pk(Z, Z, 24'h51),         pk(24'h51, 24'h51, 24'h51)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 24'h61, 1'b1, 3'b001, pk(Z, Z, 24'h61),         pk(24'h61, 24'h61, 24'h61)};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 24'h62, 1'b1, 3'b001, pk(Z, Z, 24'h62),         pk(24'h62, 24'h62, 24'h62)};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 24'h71, 1'b1, 3'b011, pk(Z, 24'h61, 24'h71),    pk(24'h61, 24'h61, 24'h71)};

    // ---- Reset held with dv_i toggling, then released idle ----
    rst = 1'b0; dv_i = 1'b0; line_end = 1'b0; frame_start = 1'b0; data_i = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dv_i = ~dv_i; data_i = W'(32'h5A5A5A + i);
      @(posedge clk);
      #1;
      check("reset dv_o", BW'(dv0), '0);
      check("reset buff_o", buff0, '0);
    end
    @(negedge clk);
    dv_i = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle dv_o", BW'(dv0), '0);
    check("idle buff_o", buff0, '0);
    check("idle buff_o mode1", buff1, '0);
    check("idle lines_valid_o", BW'(lv0), '0);
    check("idle overflow_o", BW'(ovf0), '0);

    // ---- Three-line ramp with random dv_i bubbles mid-line ----
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < MW; c++) begin
        if (c == 2 || c == 5) begin
          repeat ($urandom_range(1, 5)) step(1'b0, 1'b0, 1'b0, W'(32'hDEAD));
        end
        px = W'(16 * l + c);
        step(1'b1, (c == MW - 1), (l == 0 && c == 0), px);
        if (l == 0 && c == 4) begin
          check("line0 upper taps zero", buff0[BW-1:W], '0);
          check("line0 lines_valid", BW'(lv0), BW'(3'b001));
        end
        if (l == 1 && c == 2) begin
          check("mode1 line1 col2 taps", buff1, pk(24'h02, 24'h02, 24'h12));
          check("mode1 line1 lines_valid", BW'(lv1), BW'(3'b011));
        end
        if (l == 2 && c == 3) begin
          check("ramp line2 col3 taps", buff0, pk(24'h03, 24'h13, 24'h23));
          check("ramp line2 lines_valid", BW'(lv0), BW'(3'b111));
        end
      end
    end

    // ---- Reset in the middle of a line, then a frame without frame_start ----
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, W'(32'h30 + c));
    @(negedge clk);
    dv_i = 1'b0; line_end = 1'b0; frame_start = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async reset dv_o", BW'(dv0), '0);
    check("async reset buff_o", buff0, '0);
    check("async reset lines_valid", BW'(lv0), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < MW; c++) step(1'b1, (c == MW - 1), 1'b0, W'(32'hA00 + 16 * l + c));
    end
    check("post-reset line1 lines_valid", BW'(lv0), BW'(3'b011));

    // ---- Overflow: 10 pixels on an 8-pixel line ----
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, (c == 0), W'(32'hB00 + c));
    check("overflow set", BW'(ovf0), BW'(1'b1));
    step(1'b0, 1'b1, 1'b0, '0);
    check("overflow held across line_end", BW'(ovf0), BW'(1'b1));
    step(1'b1, 1'b0, 1'b0, W'(32'hC00));
    step(1'b0, 1'b0, 1'b1, '0);
    check("overflow cleared by frame_start", BW'(ovf0), '0);

    // ---- Table-driven vectors ----
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].dv, tbl[i].le, tbl[i].fs, tbl[i].d);
      check($sformatf("vec%0d dv_o", i), BW'(dv0), BW'(tbl[i].e_dv));
      check($sformatf("vec%0d lines_valid", i), BW'(lv0), BW'(tbl[i].e_lv));
      check($sformatf("vec%0d taps", i), buff0, tbl[i].e_b0);
      check($sformatf("vec%0d taps mode1", i), buff1, tbl[i].e_b1);
    end

    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
